ldpc_sparse_expand_by_e: RTL

LDPC_SPARSE_EXPAND_BY_E -- requirements
Module: ldpc_sparse_expand_by_E

---
 rtl/ldpc_sparse_expand_by_e_if.sv | 31 +++
 rtl/ldpc_sparse_expand_by_e.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ldpc_sparse_expand_by_e_if.sv
// Stream bundle for ldpc_sparse_expand_by_e: word input side and expanded beat output side.
// o_output_last exists only when LDPC_EXPAND_LAST_EN is defined.
interface ldpc_sparse_expand_by_e_if #(
  parameter int WIDTH = 96
);
  logic [WIDTH-1:0] i_input_data;
  logic             i_input_valid;
  logic             o_input_ready;
  logic [WIDTH-1:0] o_output_data;
  logic             o_output_valid;
  logic             i_output_ready;
`ifdef LDPC_EXPAND_LAST_EN
  logic             o_output_last;
`endif

  modport slave (
    input  i_input_data, i_input_valid, i_output_ready,
`ifdef LDPC_EXPAND_LAST_EN
    output o_output_last,
`endif
    output o_input_ready, o_output_data, o_output_valid
  );

  modport master (
    output i_input_data, i_input_valid, i_output_ready,
`ifdef LDPC_EXPAND_LAST_EN
    input  o_output_last,
`endif
    input  o_input_ready, o_output_data, o_output_valid
  );
endinterface

// File: rtl/ldpc_sparse_expand_by_e.sv
// Ping-pong buffered expander: each accepted word is replayed as OUTPUT_LENGTH circulant-rotated beats.
// Optional o_output_last flag is enabled by defining LDPC_EXPAND_LAST_EN.
module ldpc_sparse_expand_by_e #(
  parameter int WIDTH         = 96,
  parameter int OUTPUT_LENGTH = 11,
  parameter int SHIFT_STEP    = 7
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  ldpc_sparse_expand_by_e_if.slave      bus
);

  localparam int BW = (OUTPUT_LENGTH > 1) ? $clog2(OUTPUT_LENGTH) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(OUTPUT_LENGTH - 1);

  typedef enum logic {
    RD_WAIT = 1'b0,
    RD_EMIT = 1'b1
  } rd_state_t;

  function automatic logic [WIDTH-1:0] rotl_beat(input logic [WIDTH-1:0] x, input logic [BW-1:0] beat);
    logic [31:0]        amt;
    logic [2*WIDTH-1:0] dbl;
    amt = (32'(beat) * 32'(SHIFT_STEP)) % 32'(WIDTH);
    dbl = {x, x} << amt;
    return dbl[2*WIDTH-1 -: WIDTH];
  endfunction

  rd_state_t                state_q, state_d;
  logic [1:0][WIDTH-1:0]    stor_q, stor_d;
  logic [1:0]               full_q, full_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]            beat_q, beat_d;
  logic [WIDTH-1:0]         data_q, data_d;
`ifdef LDPC_EXPAND_LAST_EN
  logic                     last_q, last_d;
`endif
  logic                     ready_s;
  logic                     accept_s;
  logic                     hs_s;

  // Ready is masked by reset so the block never advertises space while held in reset.
  assign ready_s  = ~full_q[wr_ptr_q] & ~i_reset;
  assign accept_s = bus.i_input_valid & ready_s;
  assign hs_s     = (state_q == RD_EMIT) & bus.i_output_ready;

  // Next-state for buffers, pointers, beat counter, readout FSM and the registered output beat.
  always_comb begin
    stor_d   = stor_q;
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    state_d  = state_q;
    data_d   = '0;

    if (accept_s) begin
      stor_d[wr_ptr_q] = bus.i_input_data;
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (hs_s) begin
      if (beat_q == LAST_BEAT) begin
        full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = ~rd_ptr_q;
        beat_d           = '0;
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end else begin
      beat_d = beat_q;
    end

    // Looking at the post-update flags gives latency 1 and back-to-back blocks without a bubble.
    case (state_q)
      RD_WAIT: begin
        if (full_d[rd_ptr_d]) begin
          state_d = RD_EMIT;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_EMIT: begin
        if (hs_s && (beat_q == LAST_BEAT)) begin
          state_d = full_d[rd_ptr_d] ? RD_EMIT : RD_WAIT;
        end else begin
          state_d = RD_EMIT;
        end
      end
      default: state_d = RD_WAIT;
    endcase

    if (state_d == RD_EMIT) begin
      data_d = rotl_beat(stor_d[rd_ptr_d], beat_d);
    end else begin
      data_d = '0;
    end
  end

`ifdef LDPC_EXPAND_LAST_EN
  // Last flag accompanies the final beat of each block.
  always_comb begin
    if (state_d == RD_EMIT) begin
      last_d = (beat_d == LAST_BEAT);
    end else begin
      last_d = 1'b0;
    end
  end
`endif

  // State and output registers with asynchronous clear.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= RD_WAIT;
      stor_q   <= '0;
      full_q   <= 2'b00;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      beat_q   <= '0;
      data_q   <= '0;
`ifdef LDPC_EXPAND_LAST_EN
      last_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      stor_q   <= stor_d;
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
      data_q   <= data_d;
`ifdef LDPC_EXPAND_LAST_EN
      last_q   <= last_d;
`endif
    end
  end

  assign bus.o_input_ready  = ready_s;
  assign bus.o_output_valid = (state_q == RD_EMIT);
  assign bus.o_output_data  = data_q;
`ifdef LDPC_EXPAND_LAST_EN
  assign bus.o_output_last  = last_q;
`endif

endmodule
